// File: rtl/pattern_detector_param_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding.
// No logic; imported by the detector top.
package detector_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

endpackage

// File: rtl/pattern_detector_param_if.sv
// Control, serial data and status bundle for pattern_detector_param.
// slave = detector side, master = driver/observer side.
interface pattern_detector_param_if #(
    parameter int CNT_W  = 4,
    parameter int MCNT_W = 8
);
    logic              clk_en;
    logic              ser_in;
    logic              overlap_en;
    logic [CNT_W-1:0]  payload_len;
    logic              clr_cnt;
    logic              match;
    logic              ser_out;
    logic              ser_out_valid;
    logic [CNT_W-1:0]  cnt_out;
    logic [MCNT_W-1:0] match_cnt;
    logic              busy;

    modport slave (
        input  clk_en, ser_in, overlap_en, payload_len, clr_cnt,
        output match, ser_out, ser_out_valid, cnt_out, match_cnt, busy
    );

    modport master (
        output clk_en, ser_in, overlap_en, payload_len, clr_cnt,
        input  match, ser_out, ser_out_valid, cnt_out, match_cnt, busy
    );
endinterface

// File: rtl/pattern_detector_param_seq_counter.sv
// Enabled up-counter with sync clear; wraps or saturates at all-ones.
// Count visible the cycle after an enabled inc; co flags an increment at all-ones.
module seq_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt_out,
    output logic             co
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear together with an increment restarts the count at one, not zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clk_en) begin
            if (clr) begin
                cnt_d = inc ? WIDTH'(1) : '0;
            end else if (inc && !(SATURATE && (&cnt_q))) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;
    assign co      = clk_en && inc && (&cnt_q);
endmodule

// File: rtl/pattern_detector_param.sv
// Serial pattern detector that forwards payload_len bits after each match.
// Outputs registered: match one cycle after the final pattern bit; no backpressure.
module pattern_detector_param
    import detector_pkg::*;
#(
    parameter int                PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b110101,
    parameter int                CNT_W   = 4,
    parameter int                MCNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pattern_detector_param_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               match_q, match_d;
    logic               ser_out_q, ser_out_d;
    logic               sov_q, sov_d;
    logic               busy_q, busy_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic               hit;
    logic               pay_last;
    logic               pay_inc, pay_clr, mcnt_inc;
    logic [CNT_W-1:0]   pay_cnt;
    logic [MCNT_W-1:0]  mcnt;
    logic               pay_co_unused, mcnt_co_unused;

    // fill_q >= PAT_LEN-1 means the incoming bit completes a full window.
    assign hist_shift = {hist_q[PAT_LEN-2:0], bus.ser_in};
    assign hit        = (state_q == HUNT) && (hist_shift == PATTERN) && (fill_q >= FILL_ARM);
    assign pay_last   = (pay_cnt + 1'b1) == len_q;
    assign pay_clr    = bus.clk_en && hit && (bus.payload_len != '0);
    assign pay_inc    = bus.clk_en && (state_q == PAYLOAD);
    assign mcnt_inc   = bus.clk_en && hit;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        len_d     = len_q;
        ser_out_d = ser_out_q;
        match_d   = 1'b0;
        sov_d     = 1'b0;
        if (bus.clk_en) begin
            case (state_q)
                HUNT: begin
                    hist_d = hist_shift;
                    fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
                    if (hit) begin
                        match_d = 1'b1;
                        if (!bus.overlap_en) begin
                            hist_d = '0;
                            fill_d = '0;
                        end
                        if (bus.payload_len != '0) begin
                            len_d   = bus.payload_len;
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    ser_out_d = bus.ser_in;
                    sov_d     = 1'b1;
                    // Payload bits never seed the next search.
                    if (pay_last) begin
                        state_d = HUNT;
                        hist_d  = '0;
                        fill_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        busy_d = (state_d == PAYLOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            hist_q    <= '0;
            fill_q    <= '0;
            len_q     <= '0;
            match_q   <= 1'b0;
            ser_out_q <= 1'b0;
            sov_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            len_q     <= len_d;
            match_q   <= match_d;
            ser_out_q <= ser_out_d;
            sov_q     <= sov_d;
            busy_q    <= busy_d;
        end
    end

    seq_counter #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_pay_cnt (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (bus.clk_en),
        .inc     (pay_inc),
        .clr     (pay_clr),
        .cnt_out (pay_cnt),
        .co      (pay_co_unused)
    );

    seq_counter #(.WIDTH(MCNT_W), .SATURATE(1'b1)) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (bus.clk_en),
        .inc     (mcnt_inc),
        .clr     (bus.clr_cnt),
        .cnt_out (mcnt),
        .co      (mcnt_co_unused)
    );

    assign bus.match         = match_q;
    assign bus.ser_out       = ser_out_q;
    assign bus.ser_out_valid = sov_q;
    assign bus.cnt_out       = pay_cnt;
    assign bus.match_cnt     = mcnt;
    assign bus.busy          = busy_q;
endmodule
